// File: rtl/axi_select_multiplexer_pkg.sv
// ---------------------------------------------------------------------------
// axi_select_multiplexer_pkg
//
// Shared definitions for the select-driven AXI4-Stream multiplexer and its
// demultiplexer counterpart, so both ends agree on the width of a select
// token.
//
// Contents:
//   AXI_DATA_BITS - default AXI4-Stream data width
//   mux_state_e   - IDLE / FORWARD packet-merge state
//   selBits()     - select token width for a given stream count
// ---------------------------------------------------------------------------
package axi_select_multiplexer_pkg;

  localparam int AXI_DATA_BITS = 64;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    FORWARD = 1'b1
  } mux_state_e;

  // A single stream still needs a 1-bit token, so the width never drops to 0.
  function automatic int selBits(input int numStreams);
    int bits;
    bits = $clog2(numStreams);
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/axi_select_multiplexer_slice.sv
// ---------------------------------------------------------------------------
// axi_register_slice
//
// Single-entry AXI4-Stream output register. The slot accepts a new beat when
// it is empty or when its current beat is leaving in the same cycle, which
// keeps full throughput with only one register stage.
//
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   s_tvalid_i / s_tready_o - upstream handshake (s_tready_o is the slot-free
//                             flag and does not depend on s_tvalid_i)
//   s_tdata_i/tkeep_i/tlast_i - upstream beat
//   m_tvalid_o / m_tready_i - downstream handshake
//   m_tdata_o/tkeep_o/tlast_o - registered downstream beat
// ---------------------------------------------------------------------------
module axi_register_slice #(
  parameter  int DATA_BITS = 64,
  localparam int KEEP_BITS = DATA_BITS / 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_tvalid_i,
  output logic                 s_tready_o,
  input  logic [DATA_BITS-1:0] s_tdata_i,
  input  logic [KEEP_BITS-1:0] s_tkeep_i,
  input  logic                 s_tlast_i,
  output logic                 m_tvalid_o,
  input  logic                 m_tready_i,
  output logic [DATA_BITS-1:0] m_tdata_o,
  output logic [KEEP_BITS-1:0] m_tkeep_o,
  output logic                 m_tlast_o
);

  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [KEEP_BITS-1:0] keep_q, keep_d;
  logic                 last_q, last_d;
  logic                 slotFree;

  assign slotFree   = !valid_q || m_tready_i;
  assign s_tready_o = slotFree;

  // Load a new beat whenever the slot is free and upstream offers one;
  // otherwise drain the held beat once downstream takes it. The payload only
  // changes on a load, so it stays stable while the beat is stalled.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    if (s_tvalid_i && slotFree) begin
      valid_d = 1'b1;
      data_d  = s_tdata_i;
      keep_d  = s_tkeep_i;
      last_d  = s_tlast_i;
    end else if (m_tready_i) begin
      valid_d = 1'b0;
    end
  end

  // Output register; reset empties the slot immediately, dropping any beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  assign m_tvalid_o = valid_q;
  assign m_tdata_o  = data_q;
  assign m_tkeep_o  = keep_q;
  assign m_tlast_o  = last_q;

endmodule

// File: rtl/axi_select_multiplexer.sv
// ---------------------------------------------------------------------------
// axi_select_multiplexer
//
// Merges NUM_STREAMS AXI4-Stream inputs into one output, one whole packet at
// a time. Each token on the select stream names the input whose next packet
// (through tlast) is forwarded. Re-merges streams split by the select-driven
// demultiplexer.
//
// Ports:
//   clk, rst_n                    - clock, asynchronous active-low reset
//   select_valid_i/ready_o/data_i - select token stream (input index)
//   in_tvalid_i/in_tready_o       - per-input handshake
//   in_tdata_i/tkeep_i/tlast_i    - per-input beat
//   out_tvalid_o/out_tready_i     - merged output handshake
//   out_tdata_o/tkeep_o/tlast_o   - merged output beat (registered)
// ---------------------------------------------------------------------------
module axi_select_multiplexer
  import axi_select_multiplexer_pkg::*;
#(
  parameter  int NUM_STREAMS = 2,
  parameter  int DATA_BITS   = AXI_DATA_BITS,
  localparam int SEL_BITS    = selBits(NUM_STREAMS),
  localparam int KEEP_BITS   = DATA_BITS / 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  select_valid_i,
  output logic                                  select_ready_o,
  input  logic [SEL_BITS-1:0]                   select_data_i,
  input  logic [NUM_STREAMS-1:0]                in_tvalid_i,
  output logic [NUM_STREAMS-1:0]                in_tready_o,
  input  logic [NUM_STREAMS-1:0][DATA_BITS-1:0] in_tdata_i,
  input  logic [NUM_STREAMS-1:0][KEEP_BITS-1:0] in_tkeep_i,
  input  logic [NUM_STREAMS-1:0]                in_tlast_i,
  output logic                                  out_tvalid_o,
  input  logic                                  out_tready_i,
  output logic [DATA_BITS-1:0]                  out_tdata_o,
  output logic [KEEP_BITS-1:0]                  out_tkeep_o,
  output logic                                  out_tlast_o
);

  // One extra bit so the stream count itself is representable for the
  // range check (e.g. 4 with 2-bit tokens, or 1 with a 1-bit token).
  localparam logic [SEL_BITS:0] NUM_STREAMS_W = (SEL_BITS + 1)'(NUM_STREAMS);

  mux_state_e           state_q;
  logic [SEL_BITS-1:0]  sel_q;

  logic                 curValid;
  logic [DATA_BITS-1:0] curData;
  logic [KEEP_BITS-1:0] curKeep;
  logic                 curLast;
  logic                 slotFree;
  logic                 forwarding;
  logic                 beatHs;
  logic                 lastHs;
  logic                 selHs;
  logic                 selInRange;

  // Pick the currently selected input's beat. A compare loop instead of a
  // direct index keeps non-power-of-two stream counts free of out-of-range
  // array reads.
  always_comb begin
    curValid = 1'b0;
    curData  = '0;
    curKeep  = '0;
    curLast  = 1'b0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      if (sel_q == SEL_BITS'(i)) begin
        curValid = in_tvalid_i[i];
        curData  = in_tdata_i[i];
        curKeep  = in_tkeep_i[i];
        curLast  = in_tlast_i[i];
      end
    end
  end

  assign forwarding = (state_q == FORWARD);
  assign beatHs     = forwarding && curValid && slotFree;
  assign lastHs     = beatHs && curLast;
  assign selInRange = {1'b0, select_data_i} < NUM_STREAMS_W;

  // A new token is taken while idle, or in the very cycle the current packet's
  // tlast is consumed, so back-to-back packets need no bubble.
  assign select_ready_o = (state_q == IDLE) || lastHs;
  assign selHs          = select_valid_i && select_ready_o;

  // Only the selected input is ever readied; the others stay stalled upstream.
  always_comb begin
    in_tready_o = '0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      if (forwarding && (sel_q == SEL_BITS'(i))) begin
        in_tready_o[i] = slotFree;
      end
    end
  end

  // Packet-merge FSM. An out-of-range token is consumed like any other but
  // leaves the FSM idle, so no input is ever readied for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (selHs && selInRange) begin
            sel_q   <= select_data_i;
            state_q <= FORWARD;
          end
        end
        FORWARD: begin
          if (lastHs) begin
            if (selHs && selInRange) begin
              sel_q   <= select_data_i;
              state_q <= FORWARD;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  axi_register_slice #(
    .DATA_BITS(DATA_BITS)
  ) u_out_slice (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_tvalid_i (forwarding && curValid),
    .s_tready_o (slotFree),
    .s_tdata_i  (curData),
    .s_tkeep_i  (curKeep),
    .s_tlast_i  (curLast),
    .m_tvalid_o (out_tvalid_o),
    .m_tready_i (out_tready_i),
    .m_tdata_o  (out_tdata_o),
    .m_tkeep_o  (out_tkeep_o),
    .m_tlast_o  (out_tlast_o)
  );

endmodule

// File: tb/tb_axi_select_multiplexer.sv
// ---------------------------------------------------------------------------
// tb_axi_select_multiplexer
//
// Bench for the select-driven packet merger. A four-stream instance is driven
// by a cycle-based driver fed from per-input beat queues and a select-token
// queue; the expected merged sequence is queued alongside each token and a
// monitor pops and compares every output beat. A three-stream instance is
// driven directly to exercise out-of-range tokens.
// ---------------------------------------------------------------------------
module tb_axi_select_multiplexer;

  localparam int DW = 32;
  localparam int KW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;

  // Four-stream instance
  logic                 selValid;
  logic                 selReady;
  logic [1:0]           selData;
  logic [3:0]           inValid;
  logic [3:0]           inReady;
  logic [3:0][DW-1:0]   inData;
  logic [3:0][KW-1:0]   inKeep;
  logic [3:0]           inLast;
  logic                 outValid;
  logic                 outReady;
  logic [DW-1:0]        outData;
  logic [KW-1:0]        outKeep;
  logic                 outLast;

  // Three-stream instance
  logic                 sel3Valid;
  logic                 sel3Ready;
  logic [1:0]           sel3Data;
  logic [2:0]           in3Valid;
  logic [2:0]           in3Ready;
  logic [2:0][DW-1:0]   in3Data;
  logic [2:0][KW-1:0]   in3Keep;
  logic [2:0]           in3Last;
  logic                 out3Valid;
  logic                 out3Ready;
  logic [DW-1:0]        out3Data;
  logic [KW-1:0]        out3Keep;
  logic                 out3Last;

  // Scoreboard state
  beat_t      inQ[4][$];
  logic [1:0] selQ[$];
  beat_t      expQ[$];
  int         compared = 0;
  int         failed   = 0;
  int         beatCount = 0;

  // Driver controls
  int validPct    = 100;
  int readyPct    = 100;
  bit readyPattern = 1'b0;

  always #5 clk = ~clk;

  axi_select_multiplexer #(
    .NUM_STREAMS(4),
    .DATA_BITS  (DW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .select_valid_i(selValid),
    .select_ready_o(selReady),
    .select_data_i (selData),
    .in_tvalid_i   (inValid),
    .in_tready_o   (inReady),
    .in_tdata_i    (inData),
    .in_tkeep_i    (inKeep),
    .in_tlast_i    (inLast),
    .out_tvalid_o  (outValid),
    .out_tready_i  (outReady),
    .out_tdata_o   (outData),
    .out_tkeep_o   (outKeep),
    .out_tlast_o   (outLast)
  );

  axi_select_multiplexer #(
    .NUM_STREAMS(3),
    .DATA_BITS  (DW)
  ) dut3 (
    .clk           (clk),
    .rst_n         (rst_n),
    .select_valid_i(sel3Valid),
    .select_ready_o(sel3Ready),
    .select_data_i (sel3Data),
    .in_tvalid_i   (in3Valid),
    .in_tready_o   (in3Ready),
    .in_tdata_i    (in3Data),
    .in_tkeep_i    (in3Keep),
    .in_tlast_i    (in3Last),
    .out_tvalid_o  (out3Valid),
    .out_tready_i  (out3Ready),
    .out_tdata_o   (out3Data),
    .out_tkeep_o   (out3Keep),
    .out_tlast_o   (out3Last)
  );

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Beat k of packet 'id' from input 'src'; keep follows k so beat 0 has tkeep=0.
  function automatic beat_t beatOf(input int src, input int id, input int k, input int len);
    beat_t b;
    b.data = {4'(src), 12'(id), 16'(k)};
    b.keep = KW'(k);
    b.last = (k == len - 1);
    return b;
  endfunction

  task automatic loadPacket(input int src, input int len, input int id);
    for (int k = 0; k < len; k++) inQ[src].push_back(beatOf(src, id, k, len));
  endtask

  task automatic issueToken(input int src, input int len, input int id);
    selQ.push_back(2'(src));
    for (int k = 0; k < len; k++) expQ.push_back(beatOf(src, id, k, len));
  endtask

  task automatic applyStimulus(input int src, input int len, input int id);
    loadPacket(src, len, id);
    issueToken(src, len, id);
  endtask

  task automatic waitDrain(input string name, input int budget);
    int cycles;
    cycles = 0;
    forever begin
      @(negedge clk);
      if (expQ.size() == 0 && selQ.size() == 0 && inQ[0].size() == 0 &&
          inQ[1].size() == 0 && inQ[2].size() == 0 && inQ[3].size() == 0 &&
          !outValid && inValid == 4'b0 && !selValid) break;
      cycles++;
      if (cycles > budget) begin
        checkOutput({name, "Timeout"}, 64'(expQ.size()), 64'd0);
        break;
      end
    end
  endtask

  // Cycle-based driver for the four-stream instance: handshakes are observed
  // at the falling edge, and new values are applied just after the rising edge.
  initial begin : driver
    bit acc[4];
    bit selAcc;
    int patIdx;
    beat_t b;
    selValid = 1'b0; selData = '0;
    inValid = '0; inData = '0; inKeep = '0; inLast = '0;
    outReady = 1'b1;
    patIdx = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) acc[i] = inValid[i] && inReady[i];
      selAcc = selValid && selReady;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) inQ[i].delete();
        selQ.delete();
        inValid = '0;
        selValid = 1'b0;
        continue;
      end
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) void'(inQ[i].pop_front());
        if (!(inValid[i] && !acc[i])) begin
          if (inQ[i].size() > 0 && $urandom_range(99) < validPct) begin
            b = inQ[i][0];
            inValid[i] = 1'b1;
            inData[i]  = b.data;
            inKeep[i]  = b.keep;
            inLast[i]  = b.last;
          end else begin
            inValid[i] = 1'b0;
          end
        end
      end
      if (selAcc) void'(selQ.pop_front());
      if (!(selValid && !selAcc)) begin
        if (selQ.size() > 0 && $urandom_range(99) < validPct) begin
          selValid = 1'b1;
          selData  = selQ[0];
        end else begin
          selValid = 1'b0;
        end
      end
      if (readyPattern) begin
        outReady = (patIdx % 4 == 0) || (patIdx % 4 == 3);
        patIdx++;
      end else begin
        outReady = ($urandom_range(99) < readyPct);
      end
    end
  end

  // Monitor: pops the expected beat on every output handshake and checks
  // that a stalled beat holds its payload.
  initial begin : monitor
    bit stalled;
    beat_t held;
    beat_t got;
    beat_t exp;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        expQ.delete();
        stalled = 1'b0;
        continue;
      end
      got = {outData, outKeep, outLast};
      if (stalled) checkOutput("stableStall", 64'({outValid, got}), 64'({1'b1, held}));
      if (outValid && outReady) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedBeat", 64'(got), 64'hDEAD);
        end else begin
          exp = expQ.pop_front();
          checkOutput("beat", 64'(got), 64'(exp));
        end
        beatCount++;
      end
      stalled = outValid && !outReady;
      held = got;
    end
  end

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : main
    int startCount;
    int waited;
    rst_n = 1'b0;
    sel3Valid = 1'b0; sel3Data = '0;
    in3Valid = '0; in3Data = '0; in3Keep = '0; in3Last = '0;
    out3Ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rstOutValid", 64'(outValid), 64'd0);
    checkOutput("rstOutBeat",  64'({outData, outKeep, outLast}), 64'd0);
    checkOutput("rstInReady",  64'(inReady), 64'd0);
    checkOutput("rstSelReady", 64'(selReady), 64'd1);
    checkOutput("rst3SelReady", 64'(sel3Ready), 64'd1);
    rst_n = 1'b1;

    // Out-of-range token on the three-stream instance
    @(posedge clk); #1;
    sel3Valid = 1'b1; sel3Data = 2'd3;
    in3Valid = 3'b111; in3Last = 3'b111;
    in3Data = {32'h22, 32'h11, 32'h00};
    in3Keep = {4'h2, 4'h1, 4'h0};
    @(negedge clk);
    checkOutput("oorIdleReady", 64'(sel3Ready), 64'd1);
    @(posedge clk); #1;
    sel3Data = 2'd1;
    @(negedge clk);
    checkOutput("oorDiscardReady", 64'(in3Ready), 64'd0);
    checkOutput("oorDiscardSel",   64'(sel3Ready), 64'd1);
    checkOutput("oorNoOutput",     64'(out3Valid), 64'd0);
    @(posedge clk); #1;
    sel3Valid = 1'b0;
    @(negedge clk);
    checkOutput("oorForwardReady", 64'(in3Ready), 64'b010);
    @(posedge clk); #1;
    in3Valid = 3'b101;
    @(negedge clk);
    checkOutput("oorOutValid", 64'(out3Valid), 64'd1);
    checkOutput("oorOutBeat",  64'({out3Data, out3Keep, out3Last}), 64'({32'h11, 4'h1, 1'b1}));
    repeat (3) begin
      @(negedge clk);
      checkOutput("oorOthersIdle", 64'(in3Ready), 64'd0);
    end
    in3Valid = '0;

    // Basic merge 2,0,3 with continuous flow and no bubble between packets
    validPct = 100; readyPct = 100;
    applyStimulus(2, 3, 1);
    applyStimulus(0, 1, 2);
    applyStimulus(3, 2, 3);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!outValid && waited < 50);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      checkOutput("noBubble", 64'(outValid && outReady), 64'd1);
    end
    waitDrain("basic", 200);

    // Back-pressure 1,0,0,1 on an 8-beat packet from input 1
    readyPattern = 1'b1;
    applyStimulus(1, 8, 4);
    waitDrain("backPressure", 400);
    readyPattern = 1'b0;
    repeat (2) @(negedge clk);

    // Select starvation: valid inputs without a token are never readied
    loadPacket(0, 2, 5);
    loadPacket(1, 3, 6);
    repeat (10) begin
      @(negedge clk);
      checkOutput("starveInReady", 64'(inReady), 64'd0);
      checkOutput("starveOutValid", 64'(outValid), 64'd0);
    end
    issueToken(1, 3, 6);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(selValid && selReady) && waited < 50);
    checkOutput("starveSelHs", 64'(selValid && selReady && selData == 2'd1), 64'd1);
    @(negedge clk);
    checkOutput("starveFwdReady", 64'(inReady), 64'b0010);
    @(negedge clk);
    checkOutput("starveFwdValid", 64'(outValid), 64'd1);
    issueToken(0, 2, 5);
    waitDrain("starve", 200);

    // Asynchronous reset during beat 2 of a 5-beat packet
    applyStimulus(0, 5, 7);
    startCount = beatCount;
    waited = 0;
    while (beatCount - startCount < 2 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("rstMidReached", 64'(beatCount - startCount), 64'd2);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checkOutput("rstMidOutValid", 64'(outValid), 64'd0);
    checkOutput("rstMidIdle", 64'({selReady, inReady}), 64'b10000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 1, 8);
    waitDrain("afterReset", 200);

    // Randomised traffic: 1000 packets in random select order
    validPct = 80; readyPct = 80;
    for (int p = 0; p < 1000; p++) begin
      applyStimulus(int'($urandom_range(3)), int'($urandom_range(16, 1)), 16 + p);
    end
    waitDrain("random", 60000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/axi_select_multiplexer.md
Name: axi_select_multiplexer

Overview:
- Merges NUM_STREAMS input AXI4S streams into one output stream, packet by packet.
- The packet order comes from a select stream: each select token names the input whose next complete packet (through tlast) is forwarded.
- Downstream counterpart of the select-driven demultiplexer; re-merges streams that were split for parallel processing.
- One registered output stage; full throughput, including back-to-back packets.

Parameters:
- NUM_STREAMS, 2, number of input streams; legal range 1..64.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- select  ready_valid_i.s  SEL_BITS  select token: index of the input that supplies the next packet.
- in[NUM_STREAMS]  AXI4S.s  AXI_DATA_BITS data, AXI_DATA_BITS/8 keep, 1 last  input streams.
- out  AXI4S.m  AXI_DATA_BITS data, AXI_DATA_BITS/8 keep, 1 last  merged output stream.

Behaviour:
- SEL_BITS = max(1, $clog2(NUM_STREAMS)).
- Reset values:
  - state = IDLE.
  - out.tvalid = 0; out.tdata, out.tkeep, out.tlast = 0.
  - All in[i].tready = 0.
  - select.ready = 1, because select.ready is combinational from state.
- FSM states: IDLE, FORWARD.
- IDLE:
  - select.ready = 1; all in[].tready = 0.
  - On select handshake with value < NUM_STREAMS: latch sel_q and go to FORWARD.
  - On select handshake with value >= NUM_STREAMS (only possible for non-power-of-two NUM_STREAMS): discard the token and stay in IDLE. No beat is forwarded.
- FORWARD:
  - slot_free = !out.tvalid || out.tready.
  - in[sel_q].tready = slot_free; all other in[].tready = 0.
  - On handshake on in[sel_q]: the output register loads tdata/tkeep/tlast unchanged and out.tvalid becomes 1 the next cycle.
  - Otherwise, if out.tready is high, out.tvalid becomes 0.
  - Latency: one cycle from input handshake to out.tvalid.
- Packet end and back-to-back packets:
  - select.ready = 1 in FORWARD only in the cycle where the tlast beat of in[sel_q] is handshaked. This is a combinational path from in.tvalid/tlast and out.tready.
  - tlast handshake with a concurrent select handshake: latch the new sel_q and stay in FORWARD. No bubble.
  - tlast handshake with no concurrent select handshake: go to IDLE.
- Beats with tkeep = 0 and single-beat packets are forwarded unchanged; single-beat packets count as complete.
- Output stability: out.tdata, out.tkeep and out.tlast hold while out.tvalid && !out.tready.
- Non-selected inputs are never consumed; their data stays stalled upstream.
- Reset mid-packet clears the state and the output register immediately. The partial packet is lost, and the upstream handles any resend.
- NUM_STREAMS = 1: the select token is still required per packet, and value 1 is discarded as out of range.

Decomposition:
- The SEL_BITS helper function belongs in the libstf shared package, so the demultiplexer and multiplexer share one select width definition.
- The FSM, sel_q register and input-side muxing stay in this module.
- Natural sub-module: axi_register_slice, a single-entry output register with the slot_free logic, reusable for other AXI4S stages.

Test Plan:
- Basic merge, NUM_STREAMS=4:
  - Stimulus: select tokens 2, 0, 3; in[2] sends a 3-beat packet, in[0] a 1-beat packet, in[3] a 2-beat packet; out.tready = 1.
  - Required: 6 output beats in order 2,2,2,0,3,3, with tlast on beats 3, 4 and 6.
  - Required: no idle cycle between packets when the next select is presented before each tlast.
- Back-pressure:
  - Stimulus: out.tready toggles 1,0,0,1 repeatedly during an 8-beat packet from in[1].
  - Required: all 8 beats arrive in order with none lost or duplicated.
  - Required: tdata is stable whenever tvalid && !tready.
- Select starvation:
  - Stimulus: in[0] and in[1] hold tvalid = 1 with no select presented for 10 cycles.
  - Required: both in[].tready = 0 and out.tvalid = 0 throughout; forwarding starts 1 cycle after a select token of 1 handshakes.
- Out-of-range select, NUM_STREAMS=3:
  - Stimulus: select tokens 3 then 1.
  - Required: token 3 consumed with no output; the packet from in[1] is forwarded next.
  - Required: in[0] and in[2] are never readied.
- Reset mid-packet:
  - Stimulus: assert rst_n = 0 asynchronously at beat 2 of a 5-beat packet.
  - Required: out.tvalid = 0 before the next clock edge, and state returns to IDLE.
  - Required: after release, a new select of 0 with a 1-beat packet is forwarded correctly.
- Randomized scoreboard:
  - Stimulus: random valid/ready, random packet lengths 1–16, random select order; 1000 packets, NUM_STREAMS = 4.
  - Required: output packet sequence equals the select order; per-input data is preserved.
